neopixel_frame_sequencer: RTL and testbench

//  Upstream feeder for NeopixelController on the 8-pixel pong strip. At each refresh

---
 rtl/neopix_pkg.sv | 51 +++++
 rtl/neopixel_frame_sequencer_refresh_timer.sv | 30 +++
 rtl/neopixel_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_neopixel_frame_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared types and the per-pixel colour rule for the pong strip frame sequencer.
package neopix_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    localparam logic [7:0] LEVEL_DEFAULT = 8'd250;

    localparam color_t COLOR_OFF   = '{r: 8'd0,          g: 8'd0,          b: 8'd0};
    localparam color_t COLOR_WHITE = '{r: LEVEL_DEFAULT, g: LEVEL_DEFAULT, b: LEVEL_DEFAULT};
    localparam color_t COLOR_RED   = '{r: LEVEL_DEFAULT, g: 8'd0,          b: 8'd0};
    localparam color_t COLOR_BLUE  = '{r: 8'd0,          g: 8'd0,          b: LEVEL_DEFAULT};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SNAP     = 3'd1,
        LOAD     = 3'd2,
        WAIT_RDY = 3'd3,
        GO       = 3'd4
    } seq_state_t;

    // Priority: game over, ball, left paddle, right paddle. A ball index past
    // last_idx never matches, so it is simply not drawn.
    function automatic color_t pixel_color(
        input logic [15:0] idx,
        input logic [15:0] ball,
        input logic [15:0] last_idx,
        input logic        left_paddle,
        input logic        right_paddle,
        input logic        game_over,
        input logic [7:0]  level
    );
        color_t c;
        if (game_over) begin
            c = '{r: level, g: 8'd0, b: 8'd0};
        end else if (idx == ball) begin
            c = '{r: level, g: level, b: level};
        end else if ((idx == 16'd0) && left_paddle) begin
            c = '{r: 8'd0, g: 8'd0, b: level};
        end else if ((idx == last_idx) && right_paddle) begin
            c = '{r: level, g: 8'd0, b: 8'd0};
        end else begin
            c = COLOR_OFF;
        end
        return c;
    endfunction

endpackage

// File: rtl/neopixel_frame_sequencer_refresh_timer.sv
// Free-running refresh counter; emits a registered one-cycle tick on each wrap.
module refresh_timer #(
    parameter int REFRESH_CYCLES = 833_333,
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] count_r;
    logic             tick_r;

    // Counter 0..REFRESH_CYCLES-1 with tick raised for the cycle after the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else if (count_r == CNT_W'(REFRESH_CYCLES - 1)) begin
            count_r <= '0;
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + CNT_W'(1);
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Snapshots game state on each refresh request and streams one colour per pixel
// into the NeopixelController, then fires go once the controller is ready.
module neopixel_frame_sequencer
    import neopix_pkg::*;
#(
    parameter int         NUM_PIXELS     = 8,
    parameter int         REFRESH_CYCLES = 833_333,
    parameter logic [7:0] LEVEL          = 8'd250,
    localparam int        PIX_W          = $clog2(NUM_PIXELS)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [PIX_W-1:0] ball_pos,
    input  logic             left_paddle,
    input  logic             right_paddle,
    input  logic             game_over,
    input  logic             force_refresh,
    input  logic             ready,
    output logic [PIX_W-1:0] pixel,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             load,
    output logic             go,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [PIX_W-1:0] LAST_IDX = PIX_W'(NUM_PIXELS - 1);

    seq_state_t       state_r, state_s;
    logic [PIX_W-1:0] idx_r, idx_s;
    logic [PIX_W-1:0] snap_ball_r, snap_ball_s;
    logic             snap_left_r, snap_left_s;
    logic             snap_right_r, snap_right_s;
    logic             snap_over_r, snap_over_s;
    logic             overrun_r, overrun_s;
    logic             tick_s;
    logic             frame_req_s;

    logic [PIX_W-1:0] pixel_r, pixel_s;
    color_t           color_r, color_s;
    logic             load_r, load_s;
    logic             go_r, go_s;

    refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk  (CLOCK_50),
        .rst  (reset),
        .tick (tick_s)
    );

    assign frame_req_s = tick_s | force_refresh;

    // Next-state, snapshot capture and the next value of every registered output.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        snap_ball_s  = snap_ball_r;
        snap_left_s  = snap_left_r;
        snap_right_s = snap_right_r;
        snap_over_s  = snap_over_r;
        overrun_s    = overrun_r;

        case (state_r)
            IDLE: begin
                if (frame_req_s) begin
                    state_s = SNAP;
                end else begin
                    state_s = IDLE;
                end
            end
            SNAP: begin
                snap_ball_s  = ball_pos;
                snap_left_s  = left_paddle;
                snap_right_s = right_paddle;
                snap_over_s  = game_over;
                idx_s        = '0;
                state_s      = LOAD;
            end
            LOAD: begin
                if (idx_r == LAST_IDX) begin
                    state_s = WAIT_RDY;
                end else begin
                    idx_s   = idx_r + PIX_W'(1);
                    state_s = LOAD;
                end
            end
            WAIT_RDY: begin
                if (ready) begin
                    state_s = GO;
                end else begin
                    state_s = WAIT_RDY;
                end
            end
            GO: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Requests are never queued; a request mid-frame only marks the overrun.
        if (frame_req_s && (state_r != IDLE)) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end

        load_s = (state_s == LOAD);
        go_s   = (state_s == GO);
        if (load_s) begin
            pixel_s = idx_s;
            color_s = pixel_color(16'(idx_s), 16'(snap_ball_s), 16'(LAST_IDX),
                                  snap_left_s, snap_right_s, snap_over_s, LEVEL);
        end else begin
            pixel_s = '0;
            color_s = COLOR_OFF;
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            snap_ball_r  <= '0;
            snap_left_r  <= 1'b0;
            snap_right_r <= 1'b0;
            snap_over_r  <= 1'b0;
            overrun_r    <= 1'b0;
            pixel_r      <= '0;
            color_r      <= COLOR_OFF;
            load_r       <= 1'b0;
            go_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            snap_ball_r  <= snap_ball_s;
            snap_left_r  <= snap_left_s;
            snap_right_r <= snap_right_s;
            snap_over_r  <= snap_over_s;
            overrun_r    <= overrun_s;
            pixel_r      <= pixel_s;
            color_r      <= color_s;
            load_r       <= load_s;
            go_r         <= go_s;
        end
    end

    assign pixel      = pixel_r;
    assign red        = color_r.r;
    assign green      = color_r.g;
    assign blue       = color_r.b;
    assign load       = load_r;
    assign go         = go_r;
    assign frame_done = go_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a 20-cycle refresh period.
module tb_neopixel_frame_sequencer;

    localparam int NP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ball_pos = 3'd0;
    logic       left_paddle = 1'b0;
    logic       right_paddle = 1'b0;
    logic       game_over = 1'b0;
    logic       force_refresh = 1'b0;
    logic       ready = 1'b0;
    logic [2:0] pixel;
    logic [7:0] red, green, blue;
    logic       load, go, frame_done, overrun;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    neopixel_frame_sequencer #(
        .NUM_PIXELS     (NP),
        .REFRESH_CYCLES (20),
        .LEVEL          (8'd250)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .ball_pos      (ball_pos),
        .left_paddle   (left_paddle),
        .right_paddle  (right_paddle),
        .game_over     (game_over),
        .force_refresh (force_refresh),
        .ready         (ready),
        .pixel         (pixel),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .load          (load),
        .go            (go),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    // Cycle k is the interval that starts just after the k-th posedge following reset release.
    task automatic adv();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        force_refresh = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({load, go, frame_done, overrun, pixel, red, green, blue} !== 31'd0) begin
            mismatched++;
            $display("FAIL reset_hold: got load=%0b go=%0b done=%0b ovr=%0b px=%0d rgb=%h, expected all 0",
                     load, go, frame_done, overrun, pixel, {red, green, blue});
        end
        apply_reset();
        for (int c = 1; c <= 3; c++) begin
            adv();
            @(negedge clk);
            compared++;
            if ({load, go, frame_done, overrun, pixel, red, green, blue} !== 31'd0) begin
                mismatched++;
                $display("FAIL reset_idle c=%0d: got load=%0b go=%0b ovr=%0b px=%0d rgb=%h, expected all 0",
                         c, load, go, overrun, pixel, {red, green, blue});
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [23:0] exp_px [NP];
        logic        exp_load, exp_go;
        logic [2:0]  exp_pix;
        logic [23:0] exp_rgb;
        int          k;
        exp_px = '{24'h0000FA, 24'h000000, 24'h000000, 24'hFAFAFA,
                   24'h000000, 24'h000000, 24'h000000, 24'hFA0000};
        apply_reset();
        ball_pos = 3'd3; left_paddle = 1'b1; right_paddle = 1'b1; game_over = 1'b0;
        ready = 1'b1; force_refresh = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            adv();
            force_refresh = 1'b0;
            @(negedge clk);
            exp_load = (c >= 2) && (c <= 9);
            k = exp_load ? c - 2 : 0;
            exp_pix = exp_load ? 3'(k) : 3'd0;
            exp_rgb = exp_load ? exp_px[k] : 24'h000000;
            exp_go = (c == 11);
            compared++;
            if ({load, pixel, red, green, blue} !== {exp_load, exp_pix, exp_rgb}) begin
                mismatched++;
                $display("FAIL basic_load c=%0d: got load=%0b px=%0d rgb=%h, expected load=%0b px=%0d rgb=%h",
                         c, load, pixel, {red, green, blue}, exp_load, exp_pix, exp_rgb);
            end
            compared++;
            if ({go, frame_done} !== {exp_go, exp_go}) begin
                mismatched++;
                $display("FAIL basic_go c=%0d: got go=%0b done=%0b, expected %0b", c, go, frame_done, exp_go);
            end
        end
    endtask

    task automatic test_ready_stall();
        apply_reset();
        ball_pos = 3'd1; left_paddle = 1'b0; right_paddle = 1'b0; game_over = 1'b0;
        ready = 1'b0; force_refresh = 1'b1;
        for (int c = 1; c <= 61; c++) begin
            adv();
            force_refresh = 1'b0;
            if (c == 59) ready = 1'b1;
            @(negedge clk);
            compared++;
            if (load !== ((c >= 2) && (c <= 9))) begin
                mismatched++;
                $display("FAIL stall_load c=%0d: got %0b, expected %0b", c, load, (c >= 2) && (c <= 9));
            end
            compared++;
            if ({go, frame_done} !== {2{c == 60}}) begin
                mismatched++;
                $display("FAIL stall_go c=%0d: got go=%0b done=%0b, expected %0b", c, go, frame_done, c == 60);
            end
        end
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_overrun: got %0b, expected 1", overrun);
        end
    endtask

    task automatic test_game_over();
        apply_reset();
        ball_pos = 3'd0; left_paddle = 1'b1; right_paddle = 1'b1; game_over = 1'b1;
        ready = 1'b1; force_refresh = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            adv();
            force_refresh = 1'b0;
            @(negedge clk);
            if ((c >= 2) && (c <= 9)) begin
                compared++;
                if ({load, pixel, red, green, blue} !== {1'b1, 3'(c - 2), 24'hFA0000}) begin
                    mismatched++;
                    $display("FAIL gameover_load c=%0d: got load=%0b px=%0d rgb=%h, expected load=1 px=%0d rgb=fa0000",
                             c, load, pixel, {red, green, blue}, c - 2);
                end
            end else begin
                compared++;
                if ({load, go} !== {1'b0, c == 11}) begin
                    mismatched++;
                    $display("FAIL gameover_ctrl c=%0d: got load=%0b go=%0b, expected load=0 go=%0b", c, load, go, c == 11);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int loads = 0;
        int gos = 0;
        apply_reset();
        ball_pos = 3'd3; left_paddle = 1'b0; right_paddle = 1'b0; game_over = 1'b0;
        ready = 1'b1; force_refresh = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            adv();
            force_refresh = (c == 4);
            @(negedge clk);
            if (load) loads++;
            if (go) gos++;
            if (c == 4 || c == 5) begin
                compared++;
                if (overrun !== (c == 5)) begin
                    mismatched++;
                    $display("FAIL overrun_flag c=%0d: got %0b, expected %0b", c, overrun, c == 5);
                end
            end
        end
        compared++;
        if (loads != 8 || gos != 1) begin
            mismatched++;
            $display("FAIL overrun_count: got loads=%0d gos=%0d, expected loads=8 gos=1", loads, gos);
        end
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_sticky: got %0b, expected 1", overrun);
        end
    endtask

    task automatic test_same_cycle();
        int gos = 0;
        apply_reset();
        ball_pos = 3'd6; left_paddle = 1'b0; right_paddle = 1'b0; game_over = 1'b0;
        ready = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            adv();
            force_refresh = (c == 20);
            @(negedge clk);
            if (go) gos++;
            compared++;
            if ({load, go} !== {(c >= 22) && (c <= 29), c == 31}) begin
                mismatched++;
                $display("FAIL same_cycle c=%0d: got load=%0b go=%0b, expected load=%0b go=%0b",
                         c, load, go, (c >= 22) && (c <= 29), c == 31);
            end
        end
        compared++;
        if (gos != 1 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL same_cycle_once: got gos=%0d overrun=%0b, expected gos=1 overrun=0", gos, overrun);
        end
    endtask

    task automatic test_snapshot();
        logic [23:0] exp_rgb;
        apply_reset();
        ball_pos = 3'd2; left_paddle = 1'b0; right_paddle = 1'b0; game_over = 1'b0;
        ready = 1'b1; force_refresh = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            adv();
            force_refresh = 1'b0;
            if (c == 4) ball_pos = 3'd5;
            @(negedge clk);
            if ((c >= 2) && (c <= 9)) begin
                exp_rgb = (c - 2 == 2) ? 24'hFAFAFA : 24'h000000;
                compared++;
                if ({load, pixel, red, green, blue} !== {1'b1, 3'(c - 2), exp_rgb}) begin
                    mismatched++;
                    $display("FAIL snapshot c=%0d: got load=%0b px=%0d rgb=%h, expected load=1 px=%0d rgb=%h",
                             c, load, pixel, {red, green, blue}, c - 2, exp_rgb);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] exp_px [NP];
        logic        exp_load;
        int          k;
        exp_px = '{24'h0000FA, 24'h000000, 24'h000000, 24'hFAFAFA,
                   24'h000000, 24'h000000, 24'h000000, 24'hFA0000};
        apply_reset();
        ball_pos = 3'd3; left_paddle = 1'b1; right_paddle = 1'b1; game_over = 1'b0;
        ready = 1'b1; force_refresh = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            adv();
            force_refresh = 1'b0;
        end
        adv();
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({load, go, pixel, red, green, blue} !== 29'd0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got load=%0b go=%0b px=%0d rgb=%h, expected all 0",
                     load, go, pixel, {red, green, blue});
        end
        apply_reset();
        for (int c = 1; c <= 32; c++) begin
            adv();
            @(negedge clk);
            exp_load = (c >= 22) && (c <= 29);
            k = exp_load ? c - 22 : 0;
            compared++;
            if ({load, pixel, red, green, blue, go} !==
                {exp_load, exp_load ? 3'(k) : 3'd0, exp_load ? exp_px[k] : 24'h000000, c == 31}) begin
                mismatched++;
                $display("FAIL midreset_tick c=%0d: got load=%0b px=%0d rgb=%h go=%0b, expected load=%0b px=%0d go=%0b",
                         c, load, pixel, {red, green, blue}, go, exp_load, k, c == 31);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ready_stall();
        test_game_over();
        test_overrun();
        test_same_cycle();
        test_snapshot();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
